// File: rtl/mem_responder.sv
// Backing-memory responder: answers single-outstanding read bursts after a fixed
// latency and accepts byte-masked single-beat writes into a word-addressed array.
module mem_responder #(
    parameter int DATA_BITS = 128,
    parameter int ADDR_BITS = 10,
    parameter int BURST     = 4,
    parameter int LATENCY   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_req_val,
    output logic                   mem_req_rdy,
    input  logic [ADDR_BITS-1:0]   mem_req_addr,
    input  logic                   mem_req_rw,
    input  logic                   mem_req_data_valid,
    output logic                   mem_req_data_ready,
    input  logic [DATA_BITS-1:0]   mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
    output logic                   mem_resp_val,
    output logic [DATA_BITS-1:0]   mem_resp_data
);

    // state  | meaning
    // IDLE   | ready for a new request
    // WDATA  | write accepted, waiting for the data beat
    // WAIT   | read accepted, counting down the latency
    // RESP   | read beats on the response port, one per cycle

    localparam int DEPTH     = 2 ** ADDR_BITS;
    localparam int MASK_BITS = DATA_BITS / 8;
    localparam int BEAT_W    = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int LAT_W     = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WDATA = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    logic [DATA_BITS-1:0] mem [DEPTH];

    state_t               state;
    state_t               state_nxt;
    logic [ADDR_BITS-1:0] addr_q;
    logic [LAT_W-1:0]     lat_cnt;
    logic [LAT_W-1:0]     lat_cnt_nxt;
    logic [BEAT_W-1:0]    beat_cnt;
    logic [BEAT_W-1:0]    beat_cnt_nxt;
    logic [ADDR_BITS-1:0] rd_addr;
    logic                 rdy_nxt;
    logic                 data_ready_nxt;
    logic                 resp_val_nxt;
    logic                 req_acc;
    logic                 wr_fire;
    logic                 lat_done;
    logic                 last_beat;

    assign req_acc   = (state == S_IDLE) && mem_req_val && mem_req_rdy;
    assign wr_fire   = (state == S_WDATA) && mem_req_data_valid && mem_req_data_ready;
    assign last_beat = (beat_cnt == BEAT_W'(BURST - 1));
    // Outputs are registered, so the beat data must be fetched one cycle early:
    // leave WAIT when the count would reach zero on the next edge.
    assign lat_done  = (lat_cnt == LAT_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_acc) begin
                    if (mem_req_rw) begin
                        state_nxt = S_WDATA;
                    end else if (LATENCY == 1) begin
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WDATA: begin
                if (wr_fire) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (lat_done) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (last_beat) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rdy_nxt        = (state_nxt == S_IDLE);
        data_ready_nxt = (state_nxt == S_WDATA);
        resp_val_nxt   = (state_nxt == S_RESP);
        lat_cnt_nxt    = lat_cnt;
        beat_cnt_nxt   = beat_cnt;
        rd_addr        = addr_q;
        case (state)
            S_IDLE: begin
                if (req_acc) begin
                    lat_cnt_nxt  = LAT_W'(LATENCY - 1);
                    beat_cnt_nxt = '0;
                    rd_addr      = mem_req_addr;
                end
            end
            S_WAIT: begin
                lat_cnt_nxt  = lat_cnt - LAT_W'(1);
                beat_cnt_nxt = '0;
                rd_addr      = addr_q;
            end
            S_RESP: begin
                // Burst address wraps naturally at ADDR_BITS; start is not realigned.
                rd_addr = addr_q + ADDR_BITS'(beat_cnt) + ADDR_BITS'(1);
                if (!last_beat) begin
                    beat_cnt_nxt = beat_cnt + BEAT_W'(1);
                end
            end
            default: begin
                rd_addr = addr_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q             <= '0;
            lat_cnt            <= '0;
            beat_cnt           <= '0;
            mem_req_rdy        <= 1'b0;
            mem_req_data_ready <= 1'b0;
            mem_resp_val       <= 1'b0;
            mem_resp_data      <= '0;
        end else begin
            if (req_acc) begin
                addr_q <= mem_req_addr;
            end
            lat_cnt            <= lat_cnt_nxt;
            beat_cnt           <= beat_cnt_nxt;
            mem_req_rdy        <= rdy_nxt;
            mem_req_data_ready <= data_ready_nxt;
            mem_resp_val       <= resp_val_nxt;
            mem_resp_data      <= resp_val_nxt ? mem[rd_addr] : '0;
        end
    end

    // Array has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < MASK_BITS; i++) begin
                if (mem_req_data_mask[i]) begin
                    mem[addr_q][8*i +: 8] <= mem_req_data_bits[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomised self-checking bench for mem_responder with a word-array model and
// a per-cycle response checker driven by expected (cycle, data) beats.
module tb_mem_responder;

    localparam int DATA_BITS = 128;
    localparam int ADDR_BITS = 10;
    localparam int BURST     = 4;
    localparam int LATENCY   = 4;
    localparam int DEPTH     = 2 ** ADDR_BITS;

    typedef struct {
        int                   cyc;
        logic [DATA_BITS-1:0] data;
    } beat_t;

    logic                   clk;
    logic                   reset;
    logic                   mem_req_val;
    logic                   mem_req_rdy;
    logic [ADDR_BITS-1:0]   mem_req_addr;
    logic                   mem_req_rw;
    logic                   mem_req_data_valid;
    logic                   mem_req_data_ready;
    logic [DATA_BITS-1:0]   mem_req_data_bits;
    logic [DATA_BITS/8-1:0] mem_req_data_mask;
    logic                   mem_resp_val;
    logic [DATA_BITS-1:0]   mem_resp_data;

    logic [DATA_BITS-1:0] model_mem [DEPTH];
    beat_t                exp_q[$];
    logic [DATA_BITS-1:0] got_q[$];
    int                   cyc;
    int                   checks;
    int                   errors;

    mem_responder #(
        .DATA_BITS (DATA_BITS),
        .ADDR_BITS (ADDR_BITS),
        .BURST     (BURST),
        .LATENCY   (LATENCY)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .mem_req_val        (mem_req_val),
        .mem_req_rdy        (mem_req_rdy),
        .mem_req_addr       (mem_req_addr),
        .mem_req_rw         (mem_req_rw),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data_bits  (mem_req_data_bits),
        .mem_req_data_mask  (mem_req_data_mask),
        .mem_resp_val       (mem_resp_val),
        .mem_resp_data      (mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DATA_BITS-1:0] got,
                       input logic [DATA_BITS-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [DATA_BITS-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Response port: a beat is due exactly when the head of exp_q names this cycle.
    always @(negedge clk) begin
        if (reset) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                chk("resp_val beat", {127'b0, mem_resp_val}, 128'd1);
                chk("resp_data beat", mem_resp_data, exp_q[0].data);
                got_q.push_back(mem_resp_data);
                void'(exp_q.pop_front());
            end else begin
                chk("resp_val idle", {127'b0, mem_resp_val}, 128'd0);
                chk("resp_data idle", mem_resp_data, 128'd0);
            end
        end
    end

    task automatic wait_rdy();
        int n = 0;
        while (!mem_req_rdy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!mem_req_rdy) begin
            errors++;
            checks++;
            $display("FAIL wait_rdy timeout: rdy=%0b expected 1", mem_req_rdy);
        end
    endtask

    // Called at a negedge; ends at a negedge.
    task automatic do_read(input logic [ADDR_BITS-1:0] a, input bit wait_done,
                           output int n_acc);
        wait_rdy();
        n_acc              = cyc;
        mem_req_val        = 1'b1;
        mem_req_rw         = 1'b0;
        mem_req_addr       = a;
        mem_req_data_valid = 1'($urandom);
        mem_req_data_bits  = rand_word();
        mem_req_data_mask  = 16'($urandom);
        for (int k = 0; k < BURST; k++) begin
            logic [ADDR_BITS-1:0] ba;
            ba = a + ADDR_BITS'(k);
            exp_q.push_back('{cyc: n_acc + LATENCY + k, data: model_mem[ba]});
        end
        @(negedge clk);
        mem_req_val  = 1'($urandom);
        mem_req_addr = 10'($urandom);
        chk("rdy low after read accept", {127'b0, mem_req_rdy}, 128'd0);
        if (wait_done) begin
            int n = 0;
            while (!mem_req_rdy && n < 1000) begin
                @(negedge clk);
                n++;
            end
            mem_req_val        = 1'b0;
            mem_req_data_valid = 1'b0;
            chk("rdy return cycle", 128'(cyc), 128'(n_acc + LATENCY + BURST));
        end
    endtask

    task automatic do_write(input logic [ADDR_BITS-1:0] a, input logic [DATA_BITS-1:0] d,
                            input logic [DATA_BITS/8-1:0] m, input int stall);
        wait_rdy();
        mem_req_val        = 1'b1;
        mem_req_rw         = 1'b1;
        mem_req_addr       = a;
        // Data beat offered while IDLE must not be consumed.
        mem_req_data_valid = 1'($urandom);
        mem_req_data_bits  = rand_word();
        mem_req_data_mask  = 16'($urandom);
        @(negedge clk);
        mem_req_val = 1'b0;
        chk("data_ready after write accept", {127'b0, mem_req_data_ready}, 128'd1);
        chk("rdy low in write data", {127'b0, mem_req_rdy}, 128'd0);
        for (int s = 0; s < stall; s++) begin
            mem_req_data_valid = 1'b0;
            mem_req_data_bits  = rand_word();
            mem_req_data_mask  = 16'($urandom);
            @(negedge clk);
            chk("data_ready held in stall", {127'b0, mem_req_data_ready}, 128'd1);
            chk("rdy low in stall", {127'b0, mem_req_rdy}, 128'd0);
        end
        mem_req_data_valid = 1'b1;
        mem_req_data_bits  = d;
        mem_req_data_mask  = m;
        @(negedge clk);
        mem_req_data_valid = 1'b0;
        for (int i = 0; i < DATA_BITS / 8; i++) begin
            if (m[i]) model_mem[a][8*i +: 8] = d[8*i +: 8];
        end
        chk("rdy after write data", {127'b0, mem_req_rdy}, 128'd1);
        chk("data_ready drop after write", {127'b0, mem_req_data_ready}, 128'd0);
    endtask

    task automatic check_got(input string name, input int k, input logic [DATA_BITS-1:0] exp);
        if (got_q.size() > k) begin
            chk(name, got_q[k], exp);
        end else begin
            chk({name, " missing"}, 128'(got_q.size()), 128'(k + 1));
        end
    endtask

    initial begin
        int n;
        checks             = 0;
        errors             = 0;
        reset              = 1'b0;
        mem_req_val        = 1'b0;
        mem_req_addr       = '0;
        mem_req_rw         = 1'b0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = '0;
        mem_req_data_mask  = '0;

        repeat (3) begin
            @(negedge clk);
            chk("rdy in reset", {127'b0, mem_req_rdy}, 128'd0);
            chk("resp_val in reset", {127'b0, mem_resp_val}, 128'd0);
            chk("data_ready in reset", {127'b0, mem_req_data_ready}, 128'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rdy one edge after release", {127'b0, mem_req_rdy}, 128'd1);

        for (int a = 0; a < DEPTH; a++) begin
            do_write(ADDR_BITS'(a), rand_word(), '1, 0);
        end

        // Full-mask write then read
        do_write(10'h010, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'hFFFF, 0);
        got_q.delete();
        do_read(10'h010, 1'b1, n);
        check_got("full write beat0", 0, 128'h00112233_44556677_8899AABB_CCDDEEFF);

        // Byte mask
        do_write(10'h005, '1, 16'hFFFF, 1);
        do_write(10'h005, '0, 16'h0003, 2);
        got_q.delete();
        do_read(10'h005, 1'b1, n);
        check_got("byte mask beat0", 0, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFF0000);

        // Wrap-around burst
        do_write(10'h3FE, 128'hC0DE_03FE, 16'hFFFF, 0);
        do_write(10'h3FF, 128'hC0DE_03FF, 16'hFFFF, 0);
        do_write(10'h000, 128'hC0DE_0000, 16'hFFFF, 0);
        do_write(10'h001, 128'hC0DE_0001, 16'hFFFF, 0);
        got_q.delete();
        do_read(10'h3FE, 1'b1, n);
        check_got("wrap beat0", 0, 128'hC0DE_03FE);
        check_got("wrap beat1", 1, 128'hC0DE_03FF);
        check_got("wrap beat2", 2, 128'hC0DE_0000);
        check_got("wrap beat3", 3, 128'hC0DE_0001);

        // Long write-data stall
        do_write(10'h020, 128'hDEAD_BEEF_0000_1111, 16'h00FF, 10);
        do_read(10'h020, 1'b1, n);

        // Reset after beat 1 of a burst
        do_read(10'h100, 1'b0, n);
        begin
            int t = 0;
            while (cyc != n + LATENCY + 1 && t < 100) begin
                @(negedge clk);
                t++;
            end
        end
        mem_req_val = 1'b0;
        #1;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("resp_val at reset assert", {127'b0, mem_resp_val}, 128'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rdy in mid reset", {127'b0, mem_req_rdy}, 128'd0);
            chk("resp_val in mid reset", {127'b0, mem_resp_val}, 128'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rdy after mid reset", {127'b0, mem_req_rdy}, 128'd1);
        do_read(10'h100, 1'b1, n);
        do_read(10'h010, 1'b1, n);

        // Write abandoned by reset before its data beat leaves the array alone
        wait_rdy();
        mem_req_val        = 1'b1;
        mem_req_rw         = 1'b1;
        mem_req_addr       = 10'h005;
        mem_req_data_valid = 1'b0;
        @(negedge clk);
        mem_req_val       = 1'b0;
        mem_req_data_bits = '1;
        mem_req_data_mask = '1;
        #1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mem_req_data_valid = 1'b0;
        @(negedge clk);
        got_q.delete();
        do_read(10'h005, 1'b1, n);
        check_got("abandoned write beat0", 0, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFF0000);

        // Randomised traffic
        for (int it = 0; it < 400; it++) begin
            logic [ADDR_BITS-1:0] a;
            a = ($urandom_range(0, 5) == 0) ? ADDR_BITS'(10'h3FC + $urandom_range(0, 3))
                                            : ADDR_BITS'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                do_read(a, 1'b1, n);
            end else begin
                do_write(a, rand_word(), 16'($urandom), $urandom_range(0, 3));
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (LATENCY + BURST + 2) @(negedge clk);
        chk("all beats delivered", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
